// File: rtl/alu_pkg.sv
// Opcode encodings and helpers shared by the pipelined ALU and the
// datapath sequencer that feeds it.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_PASA = 4'h8;
    localparam logic [3:0] OP_PASB = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_ASR  = 4'hC;
    localparam logic [3:0] OP_ROL  = 4'hD;
    localparam logic [3:0] OP_ROR  = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    // True for the opcodes whose overflow flag is meaningful.
    function automatic logic is_arith(input logic [3:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB) || (sel == OP_INC) ||
               (sel == OP_DEC) || (sel == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the sequencer, the pipelined ALU and
// the register-file writeback. The master side drives operations and
// accepts results; the slave side is the ALU itself.
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sel;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             ovf_sticky;
    logic             sticky_clr;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, sel, cin, a, b, acc_en, out_ready, sticky_clr,
        input  in_ready, out_valid, f, cout, zero, neg, ovf, ovf_sticky, acc
    );

    modport slave (
        input  in_valid, sel, cin, a, b, acc_en, out_ready, sticky_clr,
        output in_ready, out_valid, f, cout, zero, neg, ovf, ovf_sticky, acc
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU datapath. Arithmetic is done one bit
// wider so the carry/no-borrow lands in the top bit of the sum. CMP returns
// operand a on f but reports zero/neg from the difference a-b.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       sel,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] flag_src;
    logic             arith_ovf;

    // Select the result, carry-out and signed overflow for the opcode, then derive zero/neg.
    always_comb begin
        sum       = '0;
        f         = '0;
        cout      = 1'b0;
        arith_ovf = 1'b0;
        flag_src  = '0;
        case (sel)
            OP_ADD: begin
                sum       = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                f         = sum[MSB:0];
                cout      = sum[WIDTH];
                arith_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
                f         = sum[MSB:0];
                cout      = sum[WIDTH];
                arith_ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_INC: begin
                sum       = {1'b0, a} + (WIDTH+1)'(1);
                f         = sum[MSB:0];
                cout      = sum[WIDTH];
                arith_ovf = !a[MSB] && sum[MSB];
            end
            OP_DEC: begin
                sum       = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
                f         = sum[MSB:0];
                cout      = sum[WIDTH];
                arith_ovf = a[MSB] && !sum[MSB];
            end
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NOT:  f = ~a;
            OP_PASA: f = a;
            OP_PASB: f = b;
            OP_SHL: begin
                f    = {a[MSB-1:0], 1'b0};
                cout = a[MSB];
            end
            OP_SHR: begin
                f    = {1'b0, a[MSB:1]};
                cout = a[0];
            end
            OP_ASR: begin
                f    = {a[MSB], a[MSB:1]};
                cout = a[0];
            end
            OP_ROL: begin
                f    = {a[MSB-1:0], a[MSB]};
                cout = a[MSB];
            end
            OP_ROR: begin
                f    = {a[0], a[MSB:1]};
                cout = a[0];
            end
            OP_CMP: begin
                sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                f         = a;
                cout      = sum[WIDTH];
                arith_ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            default: ;
        endcase
        flag_src = (sel == OP_CMP) ? sum[MSB:0] : f;
        zero     = (flag_src == '0);
        neg      = flag_src[MSB];
        ovf      = is_arith(sel) && arith_ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU. S1 registers the accepted operation; S2 holds
// the computed result, flags, accumulator and sticky overflow. A single
// advance signal stalls both stages together when the result is not taken.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);

    logic             adv;

    logic             s1_valid;
    logic [3:0]       s1_sel;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_acc_en;

    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_f;
    logic             core_cout;
    logic             core_zero;
    logic             core_neg;
    logic             core_ovf;

    logic             out_valid_q;
    logic [WIDTH-1:0] f_q;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             sticky_q;
    logic [WIDTH-1:0] acc_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // The accumulator already holds the previous op's result by the time the next op sits in S1.
    assign core_a = s1_acc_en ? acc_q : s1_a;

    // S1: capture the upstream operation whenever the pipeline advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sel    <= OP_ADD;
            s1_cin    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_acc_en <= 1'b0;
        end else if (adv) begin
            s1_valid  <= bus.in_valid;
            s1_sel    <= bus.sel;
            s1_cin    <= bus.cin;
            s1_a      <= bus.a;
            s1_b      <= bus.b;
            s1_acc_en <= bus.acc_en;
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .sel  (s1_sel),
        .cin  (s1_cin),
        .a    (core_a),
        .b    (s1_b),
        .f    (core_f),
        .cout (core_cout),
        .zero (core_zero),
        .neg  (core_neg),
        .ovf  (core_ovf)
    );

    // S2: load result and flags, and update the accumulator for every non-CMP op.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= ACC_RESET;
        end else if (adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                f_q    <= core_f;
                cout_q <= core_cout;
                zero_q <= core_zero;
                neg_q  <= core_neg;
                ovf_q  <= core_ovf;
                if (s1_sel != OP_CMP) begin
                    acc_q <= core_f;
                end
            end
        end
    end

    // Sticky overflow: a new overflow beats a simultaneous clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (adv && s1_valid && core_ovf) begin
            sticky_q <= 1'b1;
        end else if (bus.sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.f          = f_q;
    assign bus.cout       = cout_q;
    assign bus.zero       = zero_q;
    assign bus.neg        = neg_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.acc        = acc_q;

endmodule
